// File: rtl/uart_rx_sampler_if.sv
// Receive-side consumer bundle: byte, status flags and the read strobe.
// The master side is the receiver and the slave side is the FIFO/register consumer.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Data_o;
    logic                 DataValid_o;
    logic                 FrameErr_o;
    logic                 ParityErr_o;
    logic                 Overrun_o;
    logic                 Busy_o;
    logic                 DataRead_i;
    logic [2:0]           state_dbg;

    // Handshake: DataValid_o stays high until a one-clk DataRead_i is seen while it is high.
    // A completion in that same cycle reloads the byte and keeps DataValid_o high.
    modport master (
        output Data_o, DataValid_o, FrameErr_o, ParityErr_o, Overrun_o, Busy_o, state_dbg,
        input  DataRead_i
    );

    modport slave (
        input  Data_o, DataValid_o, FrameErr_o, ParityErr_o, Overrun_o, Busy_o, state_dbg,
        output DataRead_i
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front end: 8x-oversampled, 3-sample majority vote, LSB-first deserialiser.
// Optional parity bit is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_sampler #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic AcqSig_i,
    input  logic RxEn_i,
`ifdef UART_RX_PARITY_EN
    input  logic ParityOdd_i,
`endif
    input  logic Rx_i,
    uart_rx_sampler_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic                 prev_q;
    logic [2:0]           tick_q;
    logic [3:0]           bit_q;
    logic                 s2_q, s3_q, maj_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 done_q, stop_q, par_err_q;
    logic                 maj_now;
    logic                 bit_end, mid_tick;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign maj_now  = (s2_q & s3_q) | (s2_q & rx_s) | (s3_q & rx_s);
    assign bit_end  = AcqSig_i && (tick_q == 3'd7);
    assign mid_tick = AcqSig_i && (tick_q == 3'd4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!RxEn_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (AcqSig_i && prev_q && !rx_s) state_d = S_START;
                S_START:  if (bit_end) state_d = maj_q ? S_IDLE : S_DATA;
                S_DATA: begin
                    if (bit_end && bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
                S_PARITY: if (bit_end) state_d = S_STOP;
                S_STOP:   if (mid_tick) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            prev_q    <= 1'b1;
            tick_q    <= 3'd0;
            bit_q     <= 4'd0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            maj_q     <= 1'b0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rx_i};
            done_q <= 1'b0;
            if (!RxEn_i) begin
                tick_q <= 3'd0;
                bit_q  <= 4'd0;
                prev_q <= 1'b1;
            end else if (AcqSig_i) begin
                if (state_q == S_IDLE) begin
                    // The edge tick itself is tick 0 of the start bit.
                    prev_q <= rx_s;
                    tick_q <= (prev_q && !rx_s) ? 3'd1 : 3'd0;
                end else begin
                    tick_q <= tick_q + 3'd1;
                    if (tick_q == 3'd2) s2_q  <= rx_s;
                    if (tick_q == 3'd3) s3_q  <= rx_s;
                    if (tick_q == 3'd4) maj_q <= maj_now;
                    case (state_q)
                        S_START: if (tick_q == 3'd7) bit_q <= 4'd0;
                        S_DATA: begin
                            if (tick_q == 3'd7) begin
                                shift_q <= {maj_q, shift_q[DATA_BITS-1:1]};
                                bit_q   <= bit_q + 4'd1;
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        S_PARITY: if (tick_q == 3'd7) par_err_q <= maj_q ^ (^shift_q) ^ ParityOdd_i;
`endif
                        S_STOP: begin
                            // Finish half a bit early so a back-to-back start edge is not missed.
                            if (tick_q == 3'd4) begin
                                done_q <= 1'b1;
                                stop_q <= maj_now;
                                prev_q <= maj_now;
                                tick_q <= 3'd0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.Data_o      <= '0;
            bus.DataValid_o <= 1'b0;
            bus.FrameErr_o  <= 1'b0;
            bus.ParityErr_o <= 1'b0;
            bus.Overrun_o   <= 1'b0;
        end else begin
            if (bus.DataRead_i && bus.DataValid_o) begin
                bus.DataValid_o <= 1'b0;
                bus.Overrun_o   <= 1'b0;
            end
            if (done_q) begin
                bus.Data_o      <= shift_q;
                bus.FrameErr_o  <= ~stop_q;
                bus.ParityErr_o <= par_err_q;
                bus.DataValid_o <= 1'b1;
                if (bus.DataValid_o && !bus.DataRead_i) bus.Overrun_o <= 1'b1;
            end
        end
    end

    assign bus.Busy_o    = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: AcqSig every 4 clk, 32 clk per bit, 8 data bits.
// Builds the parity steps when UART_RX_PARITY_EN is defined.
module tb_uart_rx_sampler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic acq = 1'b0;
    logic rx_en = 1'b1;
    logic rx = 1'b1;
`ifdef UART_RX_PARITY_EN
    logic parity_odd = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic prev_valid = 1'b0;

    uart_rx_sampler_if #(.DATA_BITS(8)) bus ();

    uart_rx_sampler #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .AcqSig_i(acq),
        .RxEn_i(rx_en),
`ifdef UART_RX_PARITY_EN
        .ParityOdd_i(parity_odd),
`endif
        .Rx_i(rx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        logic [1:0] div;
        div = 2'd0;
        forever begin
            @(negedge clk);
            div = div + 2'd1;
            acq = (div == 2'd0);
        end
    end

    // Valid-rise monitor for latency and frame counting.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_valid <= bus.DataValid_o;
        if (bus.DataValid_o === 1'b1 && prev_valid === 1'b0) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        send_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.DataValid_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, bus.DataValid_o}, 32'd1);
    endtask

    task automatic read_byte();
        bus.DataRead_i = 1'b1;
        @(negedge clk);
        bus.DataRead_i = 1'b0;
    endtask

    initial begin
        int lat;
        int rises;
        bus.DataRead_i = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data", {24'd0, bus.Data_o}, 32'h00);
        check("rst_valid", {31'd0, bus.DataValid_o}, 32'd0);
        check("rst_ferr", {31'd0, bus.FrameErr_o}, 32'd0);
        check("rst_perr", {31'd0, bus.ParityErr_o}, 32'd0);
        check("rst_ovr", {31'd0, bus.Overrun_o}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy_o}, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // 0x55, 8N1, latency from start edge
        send_frame(8'h55, ^8'h55, 1'b1);
        wait_valid("v55", 100);
        check("d55", {24'd0, bus.Data_o}, 32'h55);
        check("fe55", {31'd0, bus.FrameErr_o}, 32'd0);
        check("ov55", {31'd0, bus.Overrun_o}, 32'd0);
        lat = rise_cyc - start_cyc;
        check("lat55", {31'd0, (lat >= 306 && lat <= 313)}, 32'd1);
        read_byte();
        check("rd55", {31'd0, bus.DataValid_o}, 32'd0);
        repeat (40) @(negedge clk);

        // two-tick low glitch is a false start
        rises = rise_cnt;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        check("gl_busy", {31'd0, bus.Busy_o}, 32'd1);
        repeat (48) @(negedge clk);
        check("gl_idle", {31'd0, bus.Busy_o}, 32'd0);
        check("gl_valid", {31'd0, bus.DataValid_o}, 32'd0);
        check("gl_rises", rise_cnt - rises, 32'd0);

        // back-to-back frames, no read -> overrun, newest byte
        send_frame(8'hA3, ^8'hA3, 1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        wait_valid("v3c", 100);
        check("d3c", {24'd0, bus.Data_o}, 32'h3C);
        check("ov3c", {31'd0, bus.Overrun_o}, 32'd1);
        read_byte();
        check("rd3c_valid", {31'd0, bus.DataValid_o}, 32'd0);
        check("rd3c_ovr", {31'd0, bus.Overrun_o}, 32'd0);
        repeat (40) @(negedge clk);

        // 0xFF with stop bit 0 -> framing error
        send_frame(8'hFF, ^8'hFF, 1'b0);
        wait_valid("vff", 100);
        check("dff", {24'd0, bus.Data_o}, 32'hFF);
        check("feff", {31'd0, bus.FrameErr_o}, 32'd1);
        read_byte();
        repeat (40) @(negedge clk);

        // break of two frame lengths -> exactly one all-zero framed byte
        rises = rise_cnt;
        rx = 1'b0;
        repeat (640) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        check("brk_rises", rise_cnt - rises, 32'd1);
        check("brk_data", {24'd0, bus.Data_o}, 32'h00);
        check("brk_fe", {31'd0, bus.FrameErr_o}, 32'd1);
        check("brk_ovr", {31'd0, bus.Overrun_o}, 32'd0);
        read_byte();
        repeat (40) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b0, 1'b1);
        wait_valid("vp0", 100);
        check("p0_data", {24'd0, bus.Data_o}, 32'h07);
        check("p0_perr", {31'd0, bus.ParityErr_o}, 32'd1);
        read_byte();
        repeat (40) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_valid("vp1", 100);
        check("p1_perr", {31'd0, bus.ParityErr_o}, 32'd0);
        read_byte();
        repeat (40) @(negedge clk);
`endif

        // abort 0x81 mid-data with RxEn_i low, then receive 0x42
        rises = rise_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b1;
        rx_en = 1'b0;
        repeat (20) @(negedge clk);
        check("en_busy", {31'd0, bus.Busy_o}, 32'd0);
        rx_en = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h42, ^8'h42, 1'b1);
        wait_valid("v42", 100);
        check("en_rises", rise_cnt - rises, 32'd1);
        check("d42", {24'd0, bus.Data_o}, 32'h42);
        check("fe42", {31'd0, bus.FrameErr_o}, 32'd0);
        check("pe42", {31'd0, bus.ParityErr_o}, 32'd0);
        check("ov42", {31'd0, bus.Overrun_o}, 32'd0);
        read_byte();
        check("rd42", {31'd0, bus.DataValid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
